instr_encoder: RTL and testbench
================================

# instr_encoder

Sequential MIPS instruction encoder, the inverse of the control decoder. It accepts symbolic commands (operation, register numbers, immediate) over a valid/ready handshake and emits 32-bit instruction words with a word address. The supported set is exactly the subset the decoder recognises, plus two pseudo-instructions that expand to two words. It feeds instruction-memory preload and processor testbenches.

## Interface
- ADDR_W, 6, width of emitted word address (instruction memory depth 2^ADDR_W)
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at clk edge
- cmd_op  input  5  operation code: 0 ADDU, 1 SUBU, 2 AND, 3 OR, 4 SLTU, 5 MFHI, 6 MFLO, 7 MULTU, 8 JR, 9 LW, 10 SW, 11 BEQ, 12 BNE, 13 ADDIU, 14 LUI, 15 ORI, 16 J, 17 JAL, 18 LI (pseudo), 19 MUL (pseudo); 20-31 illegal
- cmd_rs, cmd_rt, cmd_rd  input  5 each  register numbers
- cmd_imm  input  32  immediate; bits [15:0] for I-type; byte target address for J/JAL; full 32 bits for LI
- instr_valid  output  1  instr holds a word
- instr_ready  input  1  consumer takes word when instr_valid && instr_ready
- instr  output  32  encoded word
- instr_addr  output  ADDR_W  word index of instr
- err  output  1  one-cycle pulse: illegal cmd_op accepted

## Operation
- Field layout:
  - R-type: op=0, rs[25:21], rt[20:16], rd[15:11], shamt=0, funct[5:0].
  - I-type: opcode, rs, rt, imm[15:0].
  - J-type: opcode, target[25:0] = cmd_imm[27:2].
- funct codes: ADDU 100001, SUBU 100011, AND 100100, OR 100101, SLTU 101011, MFHI 010000, MFLO 010010, MULTU 011001, JR 001000.
- opcodes: LW 100011, SW 101011, BEQ 000100, BNE 000101, ADDIU 001001, LUI 001111, ORI 001101, J 000010, JAL 000011.
- Unused register fields are zero:
  - MFHI/MFLO: rs=rt=0.
  - MULTU: rd=0.
  - JR: rt=rd=0.
  - LUI: rs=0.
- LI rt, imm:
  - if imm[31:16]==0: one word, ORI rt,$0,imm[15:0];
  - else two words: LUI rt,imm[31:16], then ORI rt,rt,imm[15:0].
- MUL rd,rs,rt: two words, MULTU rs,rt, then MFLO rd.
- Branch immediates are passed through unchecked.
- FSM states:
  - IDLE: cmd_ready=1, instr_valid=0. Legal accept → EMIT1, or EMIT_LAST for single-word ops. Illegal accept → IDLE, err=1 next cycle.
  - EMIT1: first word of a two-word op. Handshake → EMIT_LAST with the second word.
  - EMIT_LAST: final word. Handshake → IDLE, or directly to EMIT1/EMIT_LAST if a new command is accepted in the same cycle.
- cmd_ready = IDLE || (EMIT_LAST && instr_ready). This is a combinational path from instr_ready.
- instr_addr: counts accepted output words, starts at 0, increments on each output handshake, wraps 2^ADDR_W-1 → 0.

## Timing
- Reset (asynchronous, active-low): state IDLE, cmd_ready=1, instr_valid=0, instr=0, instr_addr=0, err=0. Any pending second word is dropped.
- Latency: command accepted at edge N → instr_valid=1 with its first word after edge N.
- Throughput: one word per cycle while instr_ready=1.
- Backpressure: while instr_valid && !instr_ready, instr and instr_addr stay stable and cmd_ready=0.
- instr_valid never deasserts without a handshake, except on reset.
- Simultaneous last-word handshake and new command: both occur at the same edge; the next word appears after that edge with instr_addr+1.
- err is high for exactly one cycle after an illegal accept. instr_addr is unchanged and no word is emitted.

## Structure
- Shared include mips_defs.vh holds the opcode and funct localparams and the cmd_op codes. The decoder shares the same constants.
- One combinational sub-module, mips_field_pack:
  - inputs: format select, opcode, rs, rt, rd, funct, imm16, target26;
  - output: 32-bit word.
- instr_encoder holds the FSM, output registers, pending second-word register and address counter.

## Test plan
- ADDU rd=3, rs=1, rt=2 → single word 0x00221821, instr_addr=0, next cmd_ready=1.
- LI rt=8, imm=0x12345678 → 0x3C081234 at addr 0, then 0x35085678 at addr 1. LI rt=8, imm=0x0000BEEF → single 0x3408BEEF.
- MUL rd=4, rs=5, rt=6 → 0x00A60019, then 0x00002012. JAL imm=0x00400010 → 0x0C100004.
- Backpressure: instr_ready low for 3 cycles on LI second word → word and instr_addr stable, cmd_ready=0. Back-to-back ADDU commands with instr_ready=1 → one word per cycle, consecutive addresses.
- cmd_op=25 → err pulses 1 cycle, instr_valid stays 0, instr_addr unchanged. Reset asserted after LI first word handshake → instr_valid=0, instr_addr=0, IDLE.
- ADDR_W=2, five ADDU commands → instr_addr sequence 0,1,2,3,0.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// MIPS encoding constants, command codes and field-bundle helpers shared by the encoder.
// Latency: none, declarations only.
// Backpressure: not applicable.
package instr_encoder_pkg;

  // R-type funct codes
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLTU  = 6'b101011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_JR    = 6'b001000;

  // Primary opcodes
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_BNE   = 6'b000101;
  localparam logic [5:0] OPC_ADDIU = 6'b001001;
  localparam logic [5:0] OPC_LUI   = 6'b001111;
  localparam logic [5:0] OPC_ORI   = 6'b001101;
  localparam logic [5:0] OPC_J     = 6'b000010;
  localparam logic [5:0] OPC_JAL   = 6'b000011;

  // Symbolic command codes on cmd_op
  localparam logic [4:0] CMD_ADDU  = 5'd0;
  localparam logic [4:0] CMD_SUBU  = 5'd1;
  localparam logic [4:0] CMD_AND   = 5'd2;
  localparam logic [4:0] CMD_OR    = 5'd3;
  localparam logic [4:0] CMD_SLTU  = 5'd4;
  localparam logic [4:0] CMD_MFHI  = 5'd5;
  localparam logic [4:0] CMD_MFLO  = 5'd6;
  localparam logic [4:0] CMD_MULTU = 5'd7;
  localparam logic [4:0] CMD_JR    = 5'd8;
  localparam logic [4:0] CMD_LW    = 5'd9;
  localparam logic [4:0] CMD_SW    = 5'd10;
  localparam logic [4:0] CMD_BEQ   = 5'd11;
  localparam logic [4:0] CMD_BNE   = 5'd12;
  localparam logic [4:0] CMD_ADDIU = 5'd13;
  localparam logic [4:0] CMD_LUI   = 5'd14;
  localparam logic [4:0] CMD_ORI   = 5'd15;
  localparam logic [4:0] CMD_J     = 5'd16;
  localparam logic [4:0] CMD_JAL   = 5'd17;
  localparam logic [4:0] CMD_LI    = 5'd18;
  localparam logic [4:0] CMD_MUL   = 5'd19;

  typedef enum logic [1:0] {FMT_R, FMT_I, FMT_J} fmt_t;

  typedef enum logic [1:0] {ST_IDLE, ST_EMIT1, ST_EMIT_LAST} state_t;

  // Everything the field packer needs except the J target, which always comes from cmd_imm
  typedef struct packed {
    fmt_t        fmt;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [15:0] imm16;
  } fields_t;

  function automatic fields_t r_fld(input logic [4:0] rs, input logic [4:0] rt,
                                    input logic [4:0] rd, input logic [5:0] fn);
    fields_t f;
    f = '0;
    f.fmt = FMT_R;
    f.rs = rs;
    f.rt = rt;
    f.rd = rd;
    f.funct = fn;
    return f;
  endfunction

  function automatic fields_t i_fld(input logic [5:0] opc, input logic [4:0] rs,
                                    input logic [4:0] rt, input logic [15:0] imm16);
    fields_t f;
    f = '0;
    f.fmt = FMT_I;
    f.opcode = opc;
    f.rs = rs;
    f.rt = rt;
    f.imm16 = imm16;
    return f;
  endfunction

  function automatic fields_t j_fld(input logic [5:0] opc);
    fields_t f;
    f = '0;
    f.fmt = FMT_J;
    f.opcode = opc;
    return f;
  endfunction

endpackage

// File: rtl/mips_field_pack.sv
// Packs opcode/register/immediate fields into one 32-bit MIPS word for R, I or J format.
// Latency: purely combinational.
// Backpressure: none, no state.
module mips_field_pack
  import instr_encoder_pkg::*;
(
  input  fmt_t        fmt,
  input  logic [5:0]  opcode,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [5:0]  funct,
  input  logic [15:0] imm16,
  input  logic [25:0] target26,
  output logic [31:0] word
);

  // Select the bit layout for the requested format; R-type always has op=0 and shamt=0
  always_comb begin
    word = '0;
    case (fmt)
      FMT_R:   word = {6'b000000, rs, rt, rd, 5'b00000, funct};
      FMT_I:   word = {opcode, rs, rt, imm16};
      FMT_J:   word = {opcode, target26};
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Symbolic command to MIPS word encoder; LI/MUL pseudo-ops expand to two words.
// Latency: first word valid the cycle after the command is accepted.
// Backpressure: holds word/address while instr_ready is low; cmd_ready only when idle or last word leaves.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [4:0]        cmd_op,
  input  logic [4:0]        cmd_rs,
  input  logic [4:0]        cmd_rt,
  input  logic [4:0]        cmd_rd,
  input  logic [31:0]       cmd_imm,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_addr,
  output logic              err
);

  state_t      state, state_n;
  fields_t     f0, f1;
  logic [31:0] w0, w1, pend;
  logic        two_word, illegal;
  logic        accept, out_hs, ld_cmd, err_n;

  assign instr_valid = (state != ST_IDLE);
  assign cmd_ready   = (state == ST_IDLE) || ((state == ST_EMIT_LAST) && instr_ready);
  assign accept      = cmd_valid && cmd_ready;
  assign out_hs      = instr_valid && instr_ready;

  // Translate the command into field bundles for the first and (optional) second word
  always_comb begin
    f0 = r_fld(5'd0, 5'd0, 5'd0, 6'd0);
    f1 = r_fld(5'd0, 5'd0, 5'd0, 6'd0);
    two_word = 1'b0;
    illegal  = 1'b0;
    case (cmd_op)
      CMD_ADDU:  f0 = r_fld(cmd_rs, cmd_rt, cmd_rd, FN_ADDU);
      CMD_SUBU:  f0 = r_fld(cmd_rs, cmd_rt, cmd_rd, FN_SUBU);
      CMD_AND:   f0 = r_fld(cmd_rs, cmd_rt, cmd_rd, FN_AND);
      CMD_OR:    f0 = r_fld(cmd_rs, cmd_rt, cmd_rd, FN_OR);
      CMD_SLTU:  f0 = r_fld(cmd_rs, cmd_rt, cmd_rd, FN_SLTU);
      CMD_MFHI:  f0 = r_fld(5'd0, 5'd0, cmd_rd, FN_MFHI);
      CMD_MFLO:  f0 = r_fld(5'd0, 5'd0, cmd_rd, FN_MFLO);
      CMD_MULTU: f0 = r_fld(cmd_rs, cmd_rt, 5'd0, FN_MULTU);
      CMD_JR:    f0 = r_fld(cmd_rs, 5'd0, 5'd0, FN_JR);
      CMD_LW:    f0 = i_fld(OPC_LW, cmd_rs, cmd_rt, cmd_imm[15:0]);
      CMD_SW:    f0 = i_fld(OPC_SW, cmd_rs, cmd_rt, cmd_imm[15:0]);
      CMD_BEQ:   f0 = i_fld(OPC_BEQ, cmd_rs, cmd_rt, cmd_imm[15:0]);
      CMD_BNE:   f0 = i_fld(OPC_BNE, cmd_rs, cmd_rt, cmd_imm[15:0]);
      CMD_ADDIU: f0 = i_fld(OPC_ADDIU, cmd_rs, cmd_rt, cmd_imm[15:0]);
      CMD_LUI:   f0 = i_fld(OPC_LUI, 5'd0, cmd_rt, cmd_imm[15:0]);
      CMD_ORI:   f0 = i_fld(OPC_ORI, cmd_rs, cmd_rt, cmd_imm[15:0]);
      CMD_J:     f0 = j_fld(OPC_J);
      CMD_JAL:   f0 = j_fld(OPC_JAL);
      CMD_LI: begin
        if (cmd_imm[31:16] == 16'd0) begin
          f0 = i_fld(OPC_ORI, 5'd0, cmd_rt, cmd_imm[15:0]);
        end else begin
          f0 = i_fld(OPC_LUI, 5'd0, cmd_rt, cmd_imm[31:16]);
          f1 = i_fld(OPC_ORI, cmd_rt, cmd_rt, cmd_imm[15:0]);
          two_word = 1'b1;
        end
      end
      CMD_MUL: begin
        f0 = r_fld(cmd_rs, cmd_rt, 5'd0, FN_MULTU);
        f1 = r_fld(5'd0, 5'd0, cmd_rd, FN_MFLO);
        two_word = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  mips_field_pack u_pack0 (
    .fmt(f0.fmt), .opcode(f0.opcode), .rs(f0.rs), .rt(f0.rt), .rd(f0.rd),
    .funct(f0.funct), .imm16(f0.imm16), .target26(cmd_imm[27:2]), .word(w0)
  );

  mips_field_pack u_pack1 (
    .fmt(f1.fmt), .opcode(f1.opcode), .rs(f1.rs), .rt(f1.rt), .rd(f1.rd),
    .funct(f1.funct), .imm16(f1.imm16), .target26(cmd_imm[27:2]), .word(w1)
  );

  // Next state: a word leaving and a new command arriving may share one edge
  always_comb begin
    state_n = state;
    ld_cmd  = 1'b0;
    err_n   = 1'b0;
    if (state == ST_EMIT1 && out_hs) begin
      state_n = ST_EMIT_LAST;
    end else if (state == ST_EMIT_LAST && out_hs) begin
      state_n = ST_IDLE;
    end
    if (accept) begin
      if (illegal) begin
        err_n   = 1'b1;
        state_n = ST_IDLE;
      end else begin
        ld_cmd  = 1'b1;
        state_n = two_word ? ST_EMIT1 : ST_EMIT_LAST;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_n;
  end

  // Output word, pending second word, address counter and error pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr      <= '0;
      pend       <= '0;
      instr_addr <= '0;
      err        <= 1'b0;
    end else begin
      err <= err_n;
      if (out_hs) instr_addr <= instr_addr + ADDR_W'(1);
      if (ld_cmd) begin
        instr <= w0;
        pend  <= w1;
      end else if (state == ST_EMIT1 && out_hs) begin
        instr <= pend;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomised plus directed bench for instr_encoder against a behavioural encoding model.
// Latency: checks first word one cycle after accept, one word per cycle at full rate.
// Backpressure: stalls instr_ready and checks word/address hold and cmd_ready drop.
module tb_instr_encoder;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [4:0]    cmd_op, cmd_rs, cmd_rt, cmd_rd;
  logic [31:0]   cmd_imm;
  logic          instr_valid;
  logic          instr_ready;
  logic [31:0]   instr;
  logic [AW-1:0] instr_addr;
  logic          err;

  int            checks = 0;
  int            failures = 0;
  int            exp_addr = 0;

  instr_encoder #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd), .cmd_imm(cmd_imm),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_addr(instr_addr), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference encoder: straight from the field layout tables
  function automatic logic [31:0] rw(input logic [4:0] s, input logic [4:0] t,
                                     input logic [4:0] d, input logic [5:0] fn);
    return {6'd0, s, t, d, 5'd0, fn};
  endfunction

  function automatic logic [31:0] iw(input logic [5:0] opc, input logic [4:0] s,
                                     input logic [4:0] t, input logic [15:0] im);
    return {opc, s, t, im};
  endfunction

  function automatic void model(input int op, input logic [4:0] s, input logic [4:0] t,
                                input logic [4:0] d, input logic [31:0] im,
                                output int n, output logic [31:0] a, output logic [31:0] b);
    n = 1;
    a = '0;
    b = '0;
    case (op)
      0:  a = rw(s, t, d, 6'h21);
      1:  a = rw(s, t, d, 6'h23);
      2:  a = rw(s, t, d, 6'h24);
      3:  a = rw(s, t, d, 6'h25);
      4:  a = rw(s, t, d, 6'h2B);
      5:  a = rw(0, 0, d, 6'h10);
      6:  a = rw(0, 0, d, 6'h12);
      7:  a = rw(s, t, 0, 6'h19);
      8:  a = rw(s, 0, 0, 6'h08);
      9:  a = iw(6'h23, s, t, im[15:0]);
      10: a = iw(6'h2B, s, t, im[15:0]);
      11: a = iw(6'h04, s, t, im[15:0]);
      12: a = iw(6'h05, s, t, im[15:0]);
      13: a = iw(6'h09, s, t, im[15:0]);
      14: a = iw(6'h0F, 0, t, im[15:0]);
      15: a = iw(6'h0D, s, t, im[15:0]);
      16: a = {6'h02, im[27:2]};
      17: a = {6'h03, im[27:2]};
      18: begin
        if (im[31:16] == 16'd0) begin
          a = iw(6'h0D, 0, t, im[15:0]);
        end else begin
          n = 2;
          a = iw(6'h0F, 0, t, im[31:16]);
          b = iw(6'h0D, t, t, im[15:0]);
        end
      end
      19: begin
        n = 2;
        a = rw(s, t, 0, 6'h19);
        b = rw(0, 0, d, 6'h12);
      end
      default: n = 0;
    endcase
  endfunction

  // Issue one command from idle and follow every word it produces (or its error pulse).
  // Entered and left just after a falling edge.
  task automatic run_cmd(input string tag, input int op, input logic [4:0] s,
                         input logic [4:0] t, input logic [4:0] d, input logic [31:0] im,
                         input int n, input logic [31:0] a, input logic [31:0] b,
                         input int st0, input int st1);
    logic [31:0] w;
    int st;
    cmd_op = 5'(op);
    cmd_rs = s;
    cmd_rt = t;
    cmd_rd = d;
    cmd_imm = im;
    cmd_valid = 1'b1;
    instr_ready = 1'b1;
    #1;
    chk({tag, ":cmd_ready_idle"}, 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    if (n == 0) begin
      #1;
      chk({tag, ":err"}, 32'(err), 32'd1);
      chk({tag, ":err_novalid"}, 32'(instr_valid), 32'd0);
      chk({tag, ":err_addr"}, 32'(instr_addr), 32'(exp_addr));
      @(negedge clk);
    end else begin
      for (int i = 0; i < n; i++) begin
        w  = (i == 0) ? a : b;
        st = (i == 0) ? st0 : st1;
        instr_ready = 1'b0;
        for (int k = 0; k < st; k++) begin
          #1;
          chk({tag, ":stall_valid"}, 32'(instr_valid), 32'd1);
          chk({tag, ":stall_word"}, instr, w);
          chk({tag, ":stall_addr"}, 32'(instr_addr), 32'(exp_addr));
          chk({tag, ":stall_cmd_ready"}, 32'(cmd_ready), 32'd0);
          @(negedge clk);
        end
        instr_ready = 1'b1;
        #1;
        chk({tag, ":valid"}, 32'(instr_valid), 32'd1);
        chk({tag, ":word"}, instr, w);
        chk({tag, ":addr"}, 32'(instr_addr), 32'(exp_addr));
        chk({tag, ":cmd_ready"}, 32'(cmd_ready), (i == n - 1) ? 32'd1 : 32'd0);
        @(negedge clk);
        exp_addr = (exp_addr + 1) % (1 << AW);
      end
    end
    #1;
    chk({tag, ":done_idle"}, 32'(instr_valid), 32'd0);
    chk({tag, ":done_err"}, 32'(err), 32'd0);
    chk({tag, ":done_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst:valid", 32'(instr_valid), 32'd0);
    chk("rst:word", instr, 32'd0);
    chk("rst:addr", 32'(instr_addr), 32'd0);
    chk("rst:err", 32'(err), 32'd0);
    chk("rst:cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    exp_addr = 0;
  endtask

  initial begin
    int          n;
    logic [31:0] a, b, im;
    logic [4:0]  s, t, d;
    int          op;
    logic [31:0] bb [4];

    reset = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_rs = '0;
    cmd_rt = '0;
    cmd_rd = '0;
    cmd_imm = '0;
    instr_ready = 1'b1;
    do_reset();

    // Directed cases with hand-derived words
    run_cmd("addu", 0, 5'd1, 5'd2, 5'd3, 32'd0, 1, 32'h00221821, 32'd0, 0, 0);
    run_cmd("li_two", 18, 5'd0, 5'd8, 5'd0, 32'h12345678, 2, 32'h3C081234, 32'h35085678, 0, 3);
    run_cmd("li_one", 18, 5'd0, 5'd8, 5'd0, 32'h0000BEEF, 1, 32'h3408BEEF, 32'd0, 0, 0);
    run_cmd("mul", 19, 5'd5, 5'd6, 5'd4, 32'd0, 2, 32'h00A60019, 32'h00002012, 1, 0);
    run_cmd("jal", 17, 5'd0, 5'd0, 5'd0, 32'h00400010, 1, 32'h0C100004, 32'd0, 0, 0);
    run_cmd("illegal25", 25, 5'd1, 5'd2, 5'd3, 32'h0, 0, 32'd0, 32'd0, 0, 0);

    // Back-to-back ADDU: new command accepted on the same edge the previous word leaves
    for (int i = 0; i < 4; i++) begin
      s = 5'($urandom);
      t = 5'($urandom);
      d = 5'($urandom);
      bb[i] = {6'd0, s, t, d, 5'd0, 6'h21};
      cmd_op = 5'd0;
      cmd_rs = s;
      cmd_rt = t;
      cmd_rd = d;
      cmd_valid = 1'b1;
      instr_ready = 1'b1;
      #1;
      chk("b2b:cmd_ready", 32'(cmd_ready), 32'd1);
      if (i > 0) begin
        chk("b2b:word", instr, bb[i-1]);
        chk("b2b:addr", 32'(instr_addr), 32'(exp_addr));
        exp_addr = (exp_addr + 1) % (1 << AW);
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    #1;
    chk("b2b:last_word", instr, bb[3]);
    chk("b2b:last_addr", 32'(instr_addr), 32'(exp_addr));
    exp_addr = (exp_addr + 1) % (1 << AW);
    @(negedge clk);
    #1;
    chk("b2b:idle", 32'(instr_valid), 32'd0);

    // Reset after the first LI word has been taken drops the pending second word
    @(negedge clk);
    cmd_op = 5'd18;
    cmd_rt = 5'd8;
    cmd_imm = 32'h12345678;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    chk("rst_mid:first", instr, 32'h3C081234);
    @(negedge clk);
    #1;
    chk("rst_mid:second_pending", 32'(instr_valid), 32'd1);
    do_reset();
    @(negedge clk);
    #1;
    chk("rst_mid:dropped", 32'(instr_valid), 32'd0);

    // Address wrap: five ADDUs from reset give 0,1,2,3,0
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("wrap:addr_model", 32'(exp_addr), 32'(i % 4));
      run_cmd("wrap", 0, 5'(i), 5'(i + 1), 5'(i + 2), 32'd0, 1,
              {6'd0, 5'(i), 5'(i + 1), 5'(i + 2), 5'd0, 6'h21}, 32'd0, 0, 0);
    end

    // Random commands with random output stalls against the reference model
    for (int r = 0; r < 120; r++) begin
      op = ($urandom_range(0, 7) == 0) ? int'($urandom_range(20, 31)) : int'($urandom_range(0, 19));
      s = 5'($urandom);
      t = 5'($urandom);
      d = 5'($urandom);
      im = $urandom;
      if ($urandom_range(0, 1) == 0) im[31:16] = 16'd0;
      model(op, s, t, d, im, n, a, b);
      run_cmd($sformatf("rnd%0d_op%0d", r, op), op, s, t, d, im, n, a, b,
              int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
